// File: rtl/sha256_msg_feeder.sv
// SHA-256 message feeder: turns a host word stream into padded 512-bit blocks
// served one word per core request, and captures the final chaining hash.
module sha256_msg_feeder (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  msg_data,
  input  logic         msg_valid,
  input  logic         msg_last,
  input  logic [2:0]   msg_bytes,
  output logic         msg_ready,
  input  logic         wrapper_data_request,
  output logic [31:0]  wrapper_data,
  output logic         wrapper_data_valid,
  output logic         core_start,
  input  logic         core_done,
  input  logic [255:0] hash_in,
  output logic [255:0] digest,
  output logic         digest_valid,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, START, FEED, WAIT_DONE} state_e;

  state_e         state_q, state_d;
  logic           pending_q, pending_d;
  logic [3:0]     index_q, index_d;
  logic [60:0]    byte_cnt_q, byte_cnt_d;
  logic           msg_phase_q, msg_phase_d;
  logic           pad_done_q, pad_done_d;
  logic           len_hi_sent_q, len_hi_sent_d;
  logic           final_blk_q, final_blk_d;
  logic [31:0]    wrapper_data_q, wrapper_data_d;
  logic           wrapper_data_valid_q, wrapper_data_valid_d;
  logic [255:0]   digest_q, digest_d;
  logic           digest_valid_q, digest_valid_d;

  logic           want;
  logic           serve;
  logic [2:0]     last_bytes;
  logic [31:0]    src_word;
  logic [63:0]    bit_len;

  // Source word for the current slot: message, pad marker, zero fill or length.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    last_bytes = (msg_bytes > 3'd4) ? 3'd4 : msg_bytes;
    bit_len    = {byte_cnt_q, 3'b000};
    want       = (state_q == FEED) & (wrapper_data_request | pending_q);
    msg_ready  = want & msg_phase_q;
    serve      = want & (~msg_phase_q | msg_valid);
    src_word   = 32'h0;
    if (msg_phase_q) begin
      if (msg_last) begin
        case (last_bytes)
          3'd0:    src_word = 32'h8000_0000;
          3'd1:    src_word = {msg_data[31:24], 24'h80_0000};
          3'd2:    src_word = {msg_data[31:16], 16'h8000};
          3'd3:    src_word = {msg_data[31:8], 8'h80};
          default: src_word = msg_data;
        endcase
      end else begin
        src_word = msg_data;
      end
    end else if (!pad_done_q) begin
      src_word = 32'h8000_0000;
    end else if (index_q == 4'd14) begin
      src_word = bit_len[63:32];
    end else if (index_q == 4'd15 && len_hi_sent_q) begin
      src_word = bit_len[31:0];
    end
  end

  always_comb begin
    state_d              = state_q;
    pending_d            = pending_q;
    index_d              = index_q;
    byte_cnt_d           = byte_cnt_q;
    msg_phase_d          = msg_phase_q;
    pad_done_d           = pad_done_q;
    len_hi_sent_d        = len_hi_sent_q;
    final_blk_d          = final_blk_q;
    wrapper_data_d       = wrapper_data_q;
    wrapper_data_valid_d = 1'b0;
    digest_d             = digest_q;
    digest_valid_d       = digest_valid_q;
    core_start           = 1'b0;

    case (state_q)
      IDLE: begin
        if (msg_valid) begin
          state_d        = START;
          pending_d      = 1'b0;
          index_d        = 4'd0;
          byte_cnt_d     = 61'd0;
          msg_phase_d    = 1'b1;
          pad_done_d     = 1'b0;
          len_hi_sent_d  = 1'b0;
          final_blk_d    = 1'b0;
          digest_valid_d = 1'b0;
        end
      end
      START: begin
        core_start = 1'b1;
        state_d    = FEED;
      end
      FEED: begin
        if (serve) begin
          wrapper_data_d       = src_word;
          wrapper_data_valid_d = 1'b1;
          pending_d            = 1'b0;
          index_d              = index_q + 4'd1;
          if (msg_phase_q) begin
            byte_cnt_d = byte_cnt_q + (msg_last ? {58'd0, last_bytes} : 61'd4);
            if (msg_last) begin
              msg_phase_d = 1'b0;
              // A full last word leaves the 0x80 marker for its own slot.
              pad_done_d  = (last_bytes != 3'd4);
            end
          end else if (!pad_done_q) begin
            pad_done_d = 1'b1;
          end else if (index_q == 4'd14) begin
            len_hi_sent_d = 1'b1;
          end else if (index_q == 4'd15 && len_hi_sent_q) begin
            final_blk_d = 1'b1;
          end
          if (index_q == 4'd15) state_d = WAIT_DONE;
        end else if (want) begin
          pending_d = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (core_done) begin
          if (final_blk_q) begin
            digest_d       = hash_in;
            digest_valid_d = 1'b1;
            state_d        = IDLE;
          end else begin
            state_d = START;
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q              <= IDLE;
      pending_q            <= 1'b0;
      index_q              <= 4'd0;
      byte_cnt_q           <= 61'd0;
      msg_phase_q          <= 1'b0;
      pad_done_q           <= 1'b0;
      len_hi_sent_q        <= 1'b0;
      final_blk_q          <= 1'b0;
      wrapper_data_q       <= 32'h0;
      wrapper_data_valid_q <= 1'b0;
      digest_q             <= 256'h0;
      digest_valid_q       <= 1'b0;
    end else begin
      state_q              <= state_d;
      pending_q            <= pending_d;
      index_q              <= index_d;
      byte_cnt_q           <= byte_cnt_d;
      msg_phase_q          <= msg_phase_d;
      pad_done_q           <= pad_done_d;
      len_hi_sent_q        <= len_hi_sent_d;
      final_blk_q          <= final_blk_d;
      wrapper_data_q       <= wrapper_data_d;
      wrapper_data_valid_q <= wrapper_data_valid_d;
      digest_q             <= digest_d;
      digest_valid_q       <= digest_valid_d;
    end
  end

  assign wrapper_data       = wrapper_data_q;
  assign wrapper_data_valid = wrapper_data_valid_q;
  assign digest             = digest_q;
  assign digest_valid       = digest_valid_q;
  assign busy               = (state_q != IDLE);

endmodule

// File: tb/tb_sha256_msg_feeder.sv
// Bench for sha256_msg_feeder: standard SHA-256 byte padding model, a core
// emulator issuing requests, and one monitor comparing every served word.
module tb_sha256_msg_feeder;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  msg_data;
  logic         msg_valid;
  logic         msg_last;
  logic [2:0]   msg_bytes;
  logic         msg_ready;
  logic         wrapper_data_request;
  logic [31:0]  wrapper_data;
  logic         wrapper_data_valid;
  logic         core_start;
  logic         core_done;
  logic [255:0] hash_in;
  logic [255:0] digest;
  logic         digest_valid;
  logic         busy;

  sha256_msg_feeder dut (
    .clk                  (clk),
    .reset                (reset),
    .msg_data             (msg_data),
    .msg_valid            (msg_valid),
    .msg_last             (msg_last),
    .msg_bytes            (msg_bytes),
    .msg_ready            (msg_ready),
    .wrapper_data_request (wrapper_data_request),
    .wrapper_data         (wrapper_data),
    .wrapper_data_valid   (wrapper_data_valid),
    .core_start           (core_start),
    .core_done            (core_done),
    .hash_in              (hash_in),
    .digest               (digest),
    .digest_valid         (digest_valid),
    .busy                 (busy)
  );

  always #5 clk = ~clk;

  int           total = 0;
  int           bad = 0;
  int           start_cnt = 0;
  logic [31:0]  exp_q[$];
  logic [31:0]  rx_q[$];
  logic [7:0]   msg_q[$];
  logic [31:0]  hw_data[$];
  logic [2:0]   hw_lb;
  logic [255:0] last_hash = '0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: message bytes, 0x80, zeros to 56 mod 64, 64-bit big-endian bit length.
  task automatic build_model();
    logic [7:0]  p[$];
    logic [63:0] bits;
    logic [31:0] w;
    int          n;
    msg_q = {};
    foreach (hw_data[i]) begin
      w = hw_data[i];
      n = 4;
      if (i == hw_data.size() - 1) n = (hw_lb > 3'd4) ? 4 : int'(hw_lb);
      for (int b = 0; b < n; b++) msg_q.push_back(w[31-8*b -: 8]);
    end
    p = msg_q;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bits = 64'(msg_q.size()) << 3;
    for (int i = 7; i >= 0; i--) p.push_back(bits[i*8 +: 8]);
    exp_q = {};
    for (int i = 0; i < p.size(); i += 4) exp_q.push_back({p[i], p[i+1], p[i+2], p[i+3]});
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (wrapper_data_valid) begin
        rx_q.push_back(wrapper_data);
        check("word_was_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) check("stream_word", wrapper_data, exp_q.pop_front());
      end
      if (core_start) begin
        start_cnt++;
        check("digest_valid_clear_at_start", digest_valid, 1'b0);
      end
    end
  end

  task automatic wait_core_start();
    bit ok;
    ok = 0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      if (core_start) ok = 1;
    end
    check("core_start_seen", ok, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic serve_word(input int gap_max);
    bit got;
    got = 0;
    repeat ($urandom_range(gap_max)) begin @(posedge clk); #1; end
    wrapper_data_request = 1'b1;
    @(posedge clk); #1;
    wrapper_data_request = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      if (wrapper_data_valid) got = 1;
    end
    check("word_served", got, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic finish_block();
    logic [255:0] h;
    repeat ($urandom_range(3)) begin @(posedge clk); #1; end
    for (int k = 0; k < 8; k++) h[k*32 +: 32] = $urandom;
    hash_in   = h;
    last_hash = h;
    core_done = 1'b1;
    @(posedge clk); #1;
    core_done = 1'b0;
  endtask

  task automatic core_run(input int blocks, input int gap_max);
    for (int b = 0; b < blocks; b++) begin
      wait_core_start();
      repeat (16) serve_word(gap_max);
      finish_block();
    end
  endtask

  task automatic host_drive(input int gap_max);
    bit acc;
    foreach (hw_data[i]) begin
      acc = 0;
      repeat ($urandom_range(gap_max)) begin @(posedge clk); #1; end
      msg_valid = 1'b1;
      msg_data  = hw_data[i];
      msg_last  = (i == hw_data.size() - 1);
      msg_bytes = msg_last ? hw_lb : 3'($urandom);
      for (int c = 0; c < 300 && !acc; c++) begin
        @(negedge clk);
        if (msg_ready) acc = 1;
        @(posedge clk); #1;
      end
      check("host_word_taken", acc, 1'b1);
      msg_valid = 1'b0;
      msg_last  = 1'b0;
    end
  endtask

  task automatic end_checks(input int blocks, input int s0);
    bit dv;
    dv = 0;
    for (int c = 0; c < 20 && !dv; c++) begin
      @(negedge clk);
      if (digest_valid) dv = 1;
    end
    check("digest_valid", dv, 1'b1);
    check("digest_value", digest, last_hash);
    check("busy_after_msg", busy, 1'b0);
    check("stream_drained", exp_q.size(), 0);
    check("block_count", start_cnt - s0, blocks);
    @(posedge clk); #1;
  endtask

  task automatic run_message(input int gap_max);
    int blocks;
    int s0;
    build_model();
    blocks = exp_q.size() / 16;
    rx_q   = {};
    s0     = start_cnt;
    fork
      host_drive(gap_max);
      core_run(blocks, gap_max);
    join
    end_checks(blocks, s0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t exceeded", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    reset = 1'b1; msg_data = '0; msg_valid = 0; msg_last = 0; msg_bytes = '0;
    wrapper_data_request = 0; core_done = 0; hash_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wrapper_valid", wrapper_data_valid, 1'b0);
    check("rst_core_start", core_start, 1'b0);
    check("rst_digest", digest, 256'h0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    // "abc" with garbage in the unused byte
    hw_data = {32'h616263ff}; hw_lb = 3'd3;
    build_model();
    check("model_abc_w0", exp_q[0], 32'h61626380);
    check("model_abc_w15", exp_q[15], 32'h00000018);
    run_message(2);
    check("abc_w0", rx_q[0], 32'h61626380);
    check("abc_w14", rx_q[14], 32'h0);
    check("abc_w15", rx_q[15], 32'h00000018);
    check("abc_len", rx_q.size(), 16);
    repeat (4) begin @(posedge clk); #1; end
    check("digest_hold_valid", digest_valid, 1'b1);
    check("digest_hold_value", digest, last_hash);

    // empty message
    hw_data = {32'h12345678}; hw_lb = 3'd0;
    run_message(1);
    check("empty_w0", rx_q[0], 32'h80000000);
    check("empty_w15", rx_q[15], 32'h0);

    // 56 bytes: pad at index 14, length in a second block
    hw_data = {};
    for (int i = 0; i < 14; i++) hw_data.push_back($urandom);
    hw_lb = 3'd4;
    run_message(1);
    check("b56_len", rx_q.size(), 32);
    check("b56_pad", rx_q[14], 32'h80000000);
    check("b56_w15", rx_q[15], 32'h0);
    check("b56_lenlo", rx_q[31], 32'h000001C0);

    // 55 bytes: pad merged into index 13, single block
    hw_lb = 3'd3;
    run_message(0);
    check("b55_len", rx_q.size(), 16);
    check("b55_w13_pad", rx_q[13][7:0], 8'h80);
    check("b55_lenlo", rx_q[15], 32'h000001B8);

    // request while host idle: pending held, duplicate request ignored
    hw_data = {32'hdeadbeef}; hw_lb = 3'd4;
    build_model();
    rx_q = {};
    s0 = start_cnt;
    msg_valid = 1; msg_data = 32'hdeadbeef; msg_last = 1; msg_bytes = 3'd4;
    wait_core_start();
    msg_valid = 0;
    wrapper_data_request = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      wrapper_data_request = (c == 2);
      @(negedge clk);
      check("stall_no_word", wrapper_data_valid, 1'b0);
      check("stall_ready_held", msg_ready, 1'b1);
      @(posedge clk); #1;
    end
    wrapper_data_request = 1'b0;
    msg_valid = 1'b1;
    @(posedge clk); #1;
    msg_valid = 1'b0; msg_last = 1'b0;
    @(negedge clk);
    check("release_word_next_cycle", wrapper_data_valid, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("single_word_only", wrapper_data_valid, 1'b0);
    end
    @(posedge clk); #1;
    repeat (15) serve_word(1);
    finish_block();
    end_checks(1, s0);

    // reset at index 7 aborts the message
    exp_q = {};
    repeat (7) exp_q.push_back(32'ha5a5a5a5);
    s0 = start_cnt;
    msg_valid = 1; msg_data = 32'ha5a5a5a5; msg_last = 0; msg_bytes = 3'd0;
    wait_core_start();
    repeat (7) serve_word(0);
    check("pre_reset_words", exp_q.size(), 0);
    reset = 1'b1; msg_valid = 1'b0;
    #1;
    check("mid_rst_wdata", wrapper_data, 32'h0);
    check("mid_rst_wvalid", wrapper_data_valid, 1'b0);
    check("mid_rst_digest", digest, 256'h0);
    check("mid_rst_dvalid", digest_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", msg_ready, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    check("no_start_after_reset", start_cnt - s0, 1);

    // randomized messages, fresh length after the abort
    for (int m = 0; m < 12; m++) begin
      int nw;
      nw = $urandom_range(1, 40);
      hw_data = {};
      for (int i = 0; i < nw; i++) hw_data.push_back($urandom);
      hw_lb = 3'($urandom_range(0, 7));
      run_message($urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sha256_msg_feeder.md
SHA256_MSG_FEEDER -- requirements
Module: sha256_msg_feeder

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 clk  in  1  system clock; all flops rise-edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 msg_data  in  32  host message word, big-endian (byte 0 = [31:24]).
REQ-006 msg_valid  in  1  msg_data/msg_last/msg_bytes valid.
REQ-007 msg_last  in  1  final word of message.
REQ-008 msg_bytes  in  3  valid bytes (0..4) in the last word; ignored unless msg_last.
REQ-009 msg_ready  out  1  feeder accepts host word this cycle.
REQ-010 wrapper_data_request  in  1  core requests one word (single-cycle pulse).
REQ-011 wrapper_data  out  32  word to core.
REQ-012 wrapper_data_valid  out  1  wrapper_data valid (single-cycle pulse).
REQ-013 core_start  out  1  one-cycle pulse; core begins a 512-bit block.
REQ-014 core_done  in  1  core finished a block; hash_in valid.
REQ-015 hash_in  in  256  core chaining hash; the core chains H between blocks.
REQ-016 digest  out  256  final message digest.
REQ-017 digest_valid  out  1  digest valid.
REQ-018 busy  out  1  a message is in progress (state != IDLE).

Function
REQ-019 States SHALL be IDLE, START, FEED, WAIT_DONE.
REQ-020 IDLE->START SHALL occur on msg_valid=1; START pulses core_start for one cycle, then goes to FEED.
REQ-021 In FEED, a word SHALL be produced when (wrapper_data_request | pending) and a source word is available; wrapper_data_valid SHALL assert exactly one cycle later.
REQ-022 pending SHALL set on an unserved request and clear when served; a request while pending=1 SHALL be ignored.
REQ-023 Source order per message: message words; pad word; zero words; length high word at index 14; length low word at index 15 of the final block.
REQ-024 Message word SHALL be consumed only when msg_ready=1 and msg_valid=1; msg_ready = FEED & (request|pending) & the message phase is active.
REQ-025 Last word with msg_bytes=1..3 SHALL be sent masked, with 0x80 in the byte after the last valid byte (that is the pad word); msg_bytes=4 SHALL be followed by pad word 0x80000000; msg_bytes=0 SHALL send 0x80000000 in place of the word.
REQ-026 msg_bytes>4 SHALL be treated as 4.
REQ-027 Byte counter SHALL be 61 bits and wrap mod 2^61; bit length = count<<3, sent as {len[63:32]},{len[31:0]}.
REQ-028 If the pad word lands at index 14 or 15, the rest of the block SHALL be zeros; the next block SHALL carry zeros at 0..13 and length at 14..15.
REQ-029 The word index SHALL count 0..15; after index 15 is served, FEED->WAIT_DONE.
REQ-030 WAIT_DONE on core_done SHALL go to START if more blocks remain; otherwise digest<=hash_in, digest_valid<=1, then IDLE.
REQ-031 In WAIT_DONE and IDLE, wrapper_data_request SHALL be ignored.
REQ-032 digest/digest_valid SHALL hold until the next IDLE->START transition, which clears digest_valid.
REQ-033 Host words arriving while not in FEED message phase SHALL be back-pressured (msg_ready=0).

Reset
REQ-034 Reset SHALL force IDLE, pending=0, index=0, byte count=0.
REQ-035 Reset SHALL force all outputs to zero, including digest.
REQ-036 Reset mid-message SHALL abort with no further core_start or wrapper_data_valid.

Verification
REQ-037 "abc": msg 0x61626300, bytes=3, last -> one core_start; served 0x61626380, 13x0, 0x00000000, 0x00000018; digest=hash_in on core_done; digest_valid=1.
REQ-038 Empty: msg_bytes=0, last -> 0x80000000, 14x0, 0x00000000 at index 15.
REQ-039 56 bytes (14 full words) -> block1: 14 words, 0x80000000, 0; block2: 14x0, 0x00000000, 0x000001C0; two core_start pulses.
REQ-040 55 bytes (last bytes=3 at index 13) -> index 13 ends 0x80, index 14 = 0, index 15 = 0x000001B8; single block.
REQ-041 Request with msg_valid=0 for 5 cycles -> no wrapper_data_valid, msg_ready held; msg_valid=1 -> exactly one wrapper_data_valid the next cycle.
REQ-042 Reset asserted at index 7 -> all outputs 0, state IDLE; a new message restarts at index 0 with a fresh length.
